// File: rtl/down_timer.sv
// Loadable down-counting interval timer with start/stop/pause control.
// Define DOWN_TIMER_AUTORELOAD_EN for periodic re-arm at terminal count.
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_next;
  logic [WIDTH-1:0] out_next;
  logic             expired_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      out     <= '0;
      reload  <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      out     <= out_next;
      reload  <= reload_next;
      expired <= expired_next;
    end
  end

  always_comb begin
    state_next   = state;
    out_next     = out;
    reload_next  = reload;
    expired_next = 1'b0;
    if (load) begin
      out_next    = preset;
      reload_next = preset;
      state_next  = IDLE;
    end else if (stop) begin
      if (state == RUN)
        state_next = IDLE;
    end else if (start && state != RUN) begin
      unique case (state)
        IDLE: begin
          if (out != '0) begin
            state_next = RUN;
          end else begin
            state_next   = DONE;
            expired_next = 1'b1;
          end
        end
        DONE: begin
          if (reload != '0) begin
            out_next   = reload;
            state_next = RUN;
          end else begin
            expired_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state == RUN) begin
      // out==0 never decrements, so the count cannot wrap
      if (out > WIDTH'(1)) begin
        out_next = out - WIDTH'(1);
      end else if (out == WIDTH'(1)) begin
        expired_next = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        out_next = reload;
`else
        out_next   = '0;
        state_next = DONE;
`endif
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: vector table plus corner sequences.
// Expected values are hand-computed for the selected build.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] preset;
  logic       start;
  logic       stop;
  logic [7:0] out;
  logic       busy;
  logic       done;
  logic       expired;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       ld;
    logic       st;
    logic       sp;
    logic [7:0] pre;
    logic [7:0] eo;
    logic       eb;
    logic       ed;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  down_timer #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .preset  (preset),
    .start   (start),
    .stop    (stop),
    .out     (out),
    .busy    (busy),
    .done    (done),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] eo,
                     input logic eb, input logic ed, input logic ee);
    checks++;
    if ({out, busy, done, expired} !== {eo, eb, ed, ee}) begin
      errors++;
      $display("FAIL %s: got out=%0d busy=%b done=%b exp=%b want out=%0d busy=%b done=%b exp=%b",
               nm, out, busy, done, expired, eo, eb, ed, ee);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic ld, input logic st, input logic sp,
                       input logic [7:0] pre);
    load   = ld;
    start  = st;
    stop   = sp;
    preset = pre;
    tick();
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic add(input logic ld, input logic st, input logic sp,
                     input logic [7:0] pre, input logic [7:0] eo,
                     input logic eb, input logic ed, input logic ee);
    vec_t v;
    v.ld = ld; v.st = st; v.sp = sp; v.pre = pre;
    v.eo = eo; v.eb = eb; v.ed = ed; v.ee = ee;
    tbl.push_back(v);
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    preset = 8'd0;
    #12;
    chk("reset_state", 8'd0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", 8'd0, 0, 0, 0);

`ifndef DOWN_TIMER_AUTORELOAD_EN
    // one-shot, restart from DONE, stop+start pause, load priority
    add(1, 0, 0, 8'd5, 8'd5, 0, 0, 0);
    add(0, 1, 0, 8'd0, 8'd5, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd4, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd2, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd1, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd0, 0, 1, 1);
    add(0, 0, 0, 8'd0, 8'd0, 0, 1, 0);
    add(0, 0, 0, 8'd0, 8'd0, 0, 1, 0);
    add(0, 1, 0, 8'd0, 8'd5, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd4, 1, 0, 0);
    add(0, 1, 1, 8'd0, 8'd4, 0, 0, 0);
    add(0, 0, 0, 8'd0, 8'd4, 0, 0, 0);
    add(0, 1, 0, 8'd0, 8'd4, 1, 0, 0);
    add(0, 1, 0, 8'd0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd2, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd1, 1, 0, 0);
    add(1, 1, 0, 8'd3, 8'd3, 0, 0, 0);
    add(0, 0, 0, 8'd0, 8'd3, 0, 0, 0);
    add(0, 1, 0, 8'd0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd2, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd1, 1, 0, 0);
    add(0, 0, 0, 8'd0, 8'd0, 0, 1, 1);
    add(0, 0, 0, 8'd0, 8'd0, 0, 1, 0);
    foreach (tbl[i]) begin
      apply(tbl[i].ld, tbl[i].st, tbl[i].sp, tbl[i].pre);
      chk($sformatf("vec%0d", i), tbl[i].eo, tbl[i].eb,
          tbl[i].ed, tbl[i].ee);
    end

    // pause at 7, hold four cycles, resume for seven decrements
    apply(1, 0, 0, 8'd10);
    apply(0, 1, 0, 8'd0);
    chk("p_start", 8'd10, 1, 0, 0);
    for (int k = 9; k >= 7; k--) begin
      apply(0, 0, 0, 8'd0);
      chk("p_run", 8'(k), 1, 0, 0);
    end
    apply(0, 0, 1, 8'd0);
    chk("p_stop", 8'd7, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 8'd0);
      chk("p_hold", 8'd7, 0, 0, 0);
    end
    apply(0, 1, 0, 8'd0);
    chk("p_resume", 8'd7, 1, 0, 0);
    for (int k = 6; k >= 1; k--) begin
      apply(0, 0, 0, 8'd0);
      chk("p_dec", 8'(k), 1, 0, 0);
    end
    apply(0, 0, 0, 8'd0);
    chk("p_expire", 8'd0, 0, 1, 1);
`else
    // periodic re-arm: period 3, ten periods
    apply(1, 0, 0, 8'd3);
    apply(0, 1, 0, 8'd0);
    chk("ar_start", 8'd3, 1, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      apply(0, 0, 0, 8'd0);
      if (k % 3 == 0)
        chk("ar_wrap", 8'd3, 1, 0, 1);
      else
        chk("ar_dec", 8'(3 - (k % 3)), 1, 0, 0);
    end
    apply(1, 0, 0, 8'd1);
    apply(0, 1, 0, 8'd0);
    chk("ar1_start", 8'd1, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      apply(0, 0, 0, 8'd0);
      chk("ar1_every", 8'd1, 1, 0, 1);
    end
    apply(0, 0, 1, 8'd0);
    chk("ar1_stop", 8'd1, 0, 0, 0);
`endif

    // reload of zero: start from DONE keeps pulsing
    apply(1, 0, 0, 8'd0);
    chk("z_load", 8'd0, 0, 0, 0);
    apply(0, 1, 0, 8'd0);
    chk("z_start", 8'd0, 0, 1, 1);
    apply(0, 0, 0, 8'd0);
    chk("z_quiet", 8'd0, 0, 1, 0);
    apply(0, 1, 0, 8'd0);
    chk("z_restart", 8'd0, 0, 1, 1);

    // asynchronous reset in the middle of a run
    apply(1, 0, 0, 8'h37);
    apply(0, 1, 0, 8'd0);
    apply(0, 0, 0, 8'd0);
    chk("r_running", 8'h36, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("r_async", 8'd0, 0, 0, 0);
    #3;
    reset = 1'b0;
    tick();
    chk("r_release", 8'd0, 0, 0, 0);
    apply(0, 1, 0, 8'd0);
    chk("r_start0", 8'd0, 0, 1, 1);
    apply(0, 0, 0, 8'd0);
    chk("r_after", 8'd0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
